// File: rtl/axi_wr_req_gen.sv
// axi_wr_req_gen: AXI4 write front-end turning one AW burst plus W beats into per-beat memory requests.
// Optional WRAP burst addressing is enabled by defining AXI_WRAP_BURST_EN.
package axi_pkg;
    typedef logic [3:0]  id_t;
    typedef logic [7:0]  len_t;
    typedef logic [2:0]  size_t;
    typedef logic [1:0]  burst_t;
    typedef logic        lock_t;
    typedef logic [2:0]  prot_t;
    typedef logic [3:0]  region_t;
    typedef logic [15:0] data_t;
    typedef logic [1:0]  strb_t;
    typedef logic [1:0]  resp_t;
    typedef struct packed {
        id_t         id;
        logic [15:0] addr;
        data_t       data;
        strb_t       strb;
        logic        last;
        lock_t       lock;
        prot_t       prot;
        region_t     region;
    } wr_req_t;
endpackage

module axi_wr_req_gen
    import axi_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 255,
    parameter int unsigned BEAT_SIZE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  id_t         aw_id,
    input  logic [15:0] aw_addr,
    input  len_t        aw_len,
    input  size_t       aw_size,
    input  burst_t      aw_burst,
    input  lock_t       aw_lock,
    input  prot_t       aw_prot,
    input  region_t     aw_region,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  data_t       w_data,
    input  strb_t       w_strb,
    input  logic        w_last,
    input  logic        w_valid,
    output logic        w_ready,
    output wr_req_t     req,
    output logic        req_valid,
    input  logic        req_ready,
    output id_t         b_id,
    output resp_t       b_resp,
    output logic        b_valid,
    input  logic        b_ready
);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    state_t      state, next_state;
    id_t         id;
    logic [15:0] addr, next_addr, incr;
    len_t        len, beat;
    size_t       size;
    burst_t      burst;
    lock_t       lock;
    prot_t       prot;
    region_t     region;
    logic        err, aw_err, wrap_ok, aw_hs, w_hs, b_hs, last_beat, drained;

    assign aw_ready  = (state == IDLE) && !rst;
    assign drained   = !req_valid || req_ready;
    assign w_ready   = (state == DATA) && !rst && drained;
    assign aw_hs     = aw_valid && aw_ready;
    assign w_hs      = w_valid && w_ready;
    assign b_hs      = b_valid && b_ready;
    assign last_beat = beat == len;
    assign incr      = 16'd1 << size;

`ifdef AXI_WRAP_BURST_EN
    logic [15:0] wrap_mask;
    assign wrap_ok   = aw_len inside {8'd1, 8'd3, 8'd7, 8'd15};
    assign wrap_mask = (({8'd0, len} + 16'd1) << size) - 16'd1;
    assign next_addr = burst == 2'b01 ? addr + incr :
                       burst == 2'b10 ? (addr & ~wrap_mask) | ((addr + incr) & wrap_mask) : addr;
`else
    assign wrap_ok   = 1'b0;
    assign next_addr = burst == 2'b01 ? addr + incr : addr;
`endif

    assign aw_err = (32'(aw_size) > BEAT_SIZE) || (32'(aw_len) > MAX_LEN) ||
                    (aw_burst == 2'b11) || ((aw_burst == 2'b10) && !wrap_ok);

    always_ff @(posedge clk) state <= rst ? IDLE : next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = aw_hs ? DATA : IDLE;
            DATA:    next_state = (w_hs && last_beat) ? RESP : DATA;
            RESP:    next_state = b_hs ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id        <= '0;
            addr      <= '0;
            len       <= '0;
            size      <= '0;
            burst     <= '0;
            lock      <= '0;
            prot      <= '0;
            region    <= '0;
            beat      <= '0;
            err       <= 1'b0;
            req       <= '0;
            req_valid <= 1'b0;
            b_valid   <= 1'b0;
            b_id      <= '0;
            b_resp    <= '0;
        end else begin
            if (aw_hs) begin
                id     <= aw_id;
                addr   <= aw_addr;
                len    <= aw_len;
                size   <= aw_size;
                burst  <= aw_burst;
                lock   <= aw_lock;
                prot   <= aw_prot;
                region <= aw_region;
                beat   <= '0;
                err    <= aw_err;
            end
            // last is counter-derived; a disagreeing w_last only poisons the response
            if (w_hs) begin
                req       <= wr_req_t'{id, addr, w_data, w_strb, last_beat, lock, prot, region};
                req_valid <= 1'b1;
                addr      <= next_addr;
                beat      <= beat + 8'd1;
                if (w_last != last_beat) err <= 1'b1;
            end else if (req_ready) begin
                req_valid <= 1'b0;
            end
            if (state == RESP && !b_valid && drained) begin
                b_valid <= 1'b1;
                b_id    <= id;
                b_resp  <= err ? 2'b10 : 2'b00;
            end else if (b_hs) begin
                b_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_wr_req_gen.sv
// tb_axi_wr_req_gen: directed vector table plus backpressure and reset sequences for axi_wr_req_gen.
module tb_axi_wr_req_gen;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    id_t         aw_id;
    logic [15:0] aw_addr;
    len_t        aw_len;
    size_t       aw_size;
    burst_t      aw_burst;
    lock_t       aw_lock;
    prot_t       aw_prot;
    region_t     aw_region;
    logic        aw_valid, aw_ready;
    data_t       w_data;
    strb_t       w_strb;
    logic        w_last, w_valid, w_ready;
    wr_req_t     req;
    logic        req_valid, req_ready;
    id_t         b_id;
    resp_t       b_resp;
    logic        b_valid, b_ready;

    axi_wr_req_gen dut (
        .clk(clk), .rst(rst),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_lock(aw_lock), .aw_prot(aw_prot), .aw_region(aw_region),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .req(req), .req_valid(req_valid), .req_ready(req_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        burst_t      burst;
        logic [15:0] addr;
        len_t        len;
        size_t       size;
        id_t         id;
        int          bad_last;
        logic [63:0] ea;
        resp_t       resp;
    } vec_t;

    vec_t    vecs[7];
    wr_req_t q[$];
    int      qcyc[$];
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst && req_valid && req_ready) begin
        q.push_back(req);
        qcyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input burst_t b, input logic [15:0] a, input len_t l, input size_t s,
                           input id_t id, input int bad, input logic [63:0] ea, input resp_t r);
        vecs[i] = '{burst: b, addr: a, len: l, size: s, id: id, bad_last: bad, ea: ea, resp: r};
    endtask

    task automatic send_aw(input burst_t b, input logic [15:0] a, input len_t l, input size_t s, input id_t id);
        int t = 0;
        @(negedge clk);
        aw_burst = b; aw_addr = a; aw_len = l; aw_size = s; aw_id = id;
        aw_lock = 1'b1; aw_prot = 3'd5; aw_region = 4'hA; aw_valid = 1'b1;
        while (!aw_ready && t < 50) begin @(negedge clk); t++; end
        chk("aw_ready_wait", 64'(aw_ready), 64'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
    endtask

    task automatic send_w(input int n, input int bad_last, input logic [7:0] tag);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            w_valid = 1'b1;
            w_data  = {tag, 8'(k)};
            w_strb  = 2'(k + 1);
            w_last  = (bad_last >= 0) ? (k == bad_last) : (k == n - 1);
            @(negedge clk);
            while (!w_ready && t < 50) begin @(negedge clk); t++; end
            if (!w_ready) begin
                n_cmp++; n_bad++;
                $display("FAIL w_ready_wait: got 0 expected 1 (beat %0d)", k);
            end
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic wait_bvalid(input string tag);
        int t = 0;
        @(negedge clk);
        while (!b_valid && t < 50) begin @(negedge clk); t++; end
        chk({tag, "_bvalid"}, 64'(b_valid), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; aw_valid = 0; w_valid = 0; w_last = 0; w_data = 0; w_strb = 0;
        aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_lock = 0; aw_prot = 0; aw_region = 0;
        req_ready = 1'b1; b_ready = 1'b1;

        set_vec(0, 2'b01, 16'h1000, 8'd3, 3'd1, 4'h5, -1, {16'h1006, 16'h1004, 16'h1002, 16'h1000}, 2'b00);
        set_vec(1, 2'b00, 16'h2040, 8'd2, 3'd1, 4'h6, -1, {16'h0000, 16'h2040, 16'h2040, 16'h2040}, 2'b00);
        set_vec(2, 2'b01, 16'hFFFE, 8'd1, 3'd1, 4'h7, -1, {32'h0, 16'h0000, 16'hFFFE}, 2'b00);
        set_vec(3, 2'b01, 16'h3000, 8'd3, 3'd1, 4'h8, 1, {16'h3006, 16'h3004, 16'h3002, 16'h3000}, 2'b10);
`ifdef AXI_WRAP_BURST_EN
        set_vec(4, 2'b10, 16'h0006, 8'd3, 3'd1, 4'h9, -1, {16'h0004, 16'h0002, 16'h0000, 16'h0006}, 2'b00);
`else
        set_vec(4, 2'b10, 16'h0006, 8'd3, 3'd1, 4'h9, -1, {16'h0006, 16'h0006, 16'h0006, 16'h0006}, 2'b10);
`endif
        set_vec(5, 2'b01, 16'h4000, 8'd1, 3'd2, 4'hA, -1, {32'h0, 16'h4004, 16'h4000}, 2'b10);
        set_vec(6, 2'b11, 16'h5000, 8'd1, 3'd1, 4'hB, -1, {32'h0, 16'h5000, 16'h5000}, 2'b10);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_aw_ready", 64'(aw_ready), 64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_aw_ready", 64'(aw_ready), 64'd1);
        chk("idle_req", 64'(req), 64'd0);
        chk("idle_b", {b_id, b_resp}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            q.delete(); qcyc.delete();
            send_aw(vecs[i].burst, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].id);
            send_w(int'(vecs[i].len) + 1, vecs[i].bad_last, 8'(i));
            wait_bvalid($sformatf("v%0d", i));
            chk($sformatf("v%0d_count", i), 64'(q.size()), 64'(vecs[i].len) + 64'd1);
            chk($sformatf("v%0d_bid", i), 64'(b_id), 64'(vecs[i].id));
            chk($sformatf("v%0d_bresp", i), 64'(b_resp), 64'(vecs[i].resp));
            for (int k = 0; k < q.size() && k <= int'(vecs[i].len); k++) begin
                chk($sformatf("v%0d_addr%0d", i, k), 64'(q[k].addr), 64'(vecs[i].ea[k*16 +: 16]));
                chk($sformatf("v%0d_last%0d", i, k), 64'(q[k].last), 64'(k == int'(vecs[i].len)));
                chk($sformatf("v%0d_data%0d", i, k), {q[k].id, q[k].data, q[k].strb, q[k].lock, q[k].prot, q[k].region},
                    {vecs[i].id, 8'(i), 8'(k), 2'(k + 1), 1'b1, 3'd5, 4'hA});
            end
            if (q.size() == int'(vecs[i].len) + 1)
                chk($sformatf("v%0d_bubbles", i), 64'(qcyc[q.size()-1] - qcyc[0]), 64'(vecs[i].len));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_aw_ready_after_b", i), 64'(aw_ready), 64'd1);
            chk($sformatf("v%0d_b_dropped", i), 64'(b_valid), 64'd0);
        end

        // Downstream stall for 3 cycles mid-burst, then B held against b_ready=0
        q.delete(); qcyc.delete();
        b_ready = 1'b0;
        send_aw(2'b01, 16'h6000, 8'd3, 3'd1, 4'hC);
        fork
            send_w(4, -1, 8'h77);
            begin
                int t = 0;
                wr_req_t held;
                do begin @(negedge clk); #1; t++; end while (q.size() < 1 && t < 50);
                @(posedge clk); #1;
                req_ready = 1'b0;
                @(negedge clk);
                held = req;
                for (int j = 0; j < 3; j++) begin
                    if (j > 0) @(negedge clk);
                    chk($sformatf("stall_req_valid%0d", j), 64'(req_valid), 64'd1);
                    chk($sformatf("stall_req_stable%0d", j), 64'(req), 64'(held));
                    chk($sformatf("stall_w_ready%0d", j), 64'(w_ready), 64'd0);
                    chk($sformatf("stall_aw_ready%0d", j), 64'(aw_ready), 64'd0);
                    chk($sformatf("stall_b_valid%0d", j), 64'(b_valid), 64'd0);
                end
                @(posedge clk); #1;
                req_ready = 1'b1;
            end
        join
        wait_bvalid("stall");
        chk("stall_count_at_b", 64'(q.size()), 64'd4);
        chk("stall_bid", 64'(b_id), 64'hC);
        chk("stall_bresp", 64'(b_resp), 64'd0);
        chk("stall_aw_ready_resp", 64'(aw_ready), 64'd0);
        @(negedge clk);
        chk("stall_b_held", 64'(b_valid), 64'd1);
        chk("stall_aw_ready_held", 64'(aw_ready), 64'd0);
        b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_aw_ready_after_b", 64'(aw_ready), 64'd1);
        for (int k = 0; k < q.size() && k < 4; k++) begin
            chk($sformatf("stall_addr%0d", k), 64'(q[k].addr), 64'(16'h6000 + 16'(2 * k)));
            chk($sformatf("stall_data%0d", k), 64'(q[k].data), 64'({8'h77, 8'(k)}));
            chk($sformatf("stall_last%0d", k), 64'(q[k].last), 64'(k == 3));
        end

        // Reset in the middle of a burst
        q.delete(); qcyc.delete();
        send_aw(2'b01, 16'h7000, 8'd3, 3'd1, 4'hD);
        send_w(2, -1, 8'h88);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_aw_ready", 64'(aw_ready), 64'd0);
        chk("mid_rst_w_ready", 64'(w_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
        chk("mid_rst_b_valid", 64'(b_valid), 64'd0);
        chk("mid_rst_req", 64'(req), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aw_ready", 64'(aw_ready), 64'd1);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("post_rst_no_b%0d", j), 64'(b_valid), 64'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
